// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 matrix keypad scanner: the scanner FSM
// state type, the idle row pattern and the row/column to hex code table,
// plus small helpers for decoding a row pattern.
// ---------------------------------------------------------------------------
package keypad_pkg;

   // Scanner FSM states
   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      RELEASE  = 2'd3
   } scan_state_t;

   // Rows are pulled up, so no key pressed reads as all ones
   localparam logic [3:0] ROWS_IDLE = 4'hF;

   // Key codes indexed by {row, col}; listed from index 15 down to 0.
   //   row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: 0 F E D
   localparam logic [15:0][3:0] KEY_TABLE = {
      4'hD, 4'hE, 4'hF, 4'h0,
      4'hC, 4'h9, 4'h8, 4'h7,
      4'hB, 4'h6, 4'h5, 4'h4,
      4'hA, 4'h3, 4'h2, 4'h1
   };

   // True when exactly one row line is pulled low
   function automatic logic single_row_low(input logic [3:0] row_pat);
      case (row_pat)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   // Index of the low row in a one-hot-low pattern
   function automatic logic [1:0] row_index(input logic [3:0] row_pat);
      case (row_pat)
         4'b1101: return 2'd1;
         4'b1011: return 2'd2;
         4'b0111: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
      return KEY_TABLE[{row, col}];
   endfunction

endpackage

// File: rtl/row_synchronizer.sv
// ---------------------------------------------------------------------------
// row_synchronizer
// Two-flop synchronizer for the asynchronous keypad row lines. Both stages
// reset to all ones, which matches the idle (pulled-up) state of the rows.
//
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset
//   async_in - asynchronous input bus
//   sync_out - synchronized copy of async_in, two clocks later
// ---------------------------------------------------------------------------
module row_synchronizer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= async_in;
         sync_q <= meta_q;
      end
   end

   assign sync_out = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// ---------------------------------------------------------------------------
// keypad_scan_ctrl
// Scans a 4x4 active-low matrix keypad one column at a time, debounces
// presses and releases, and presents accepted keys on a valid/ready port.
//
// Parameters:
//   SCAN_TICKS   - clocks each column is driven before rows are sampled (>= 4)
//   DEBOUNCE_CNT - consecutive identical samples to accept press/release (>= 1)
//
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset
//   rows      - asynchronous row inputs, active-low, pulled up
//   cols      - column drive, one-hot-low, cols[0] is the leftmost column
//   key_code  - hex code of the accepted key
//   key_valid - key_code valid, held until key_ready is seen
//   key_ready - consumer accepts key_code when key_valid is also high
//   key_held  - high while a debounced key is being held down
//   overrun   - one-cycle pulse when a new key is dropped because the
//               previous one has not been consumed
// ---------------------------------------------------------------------------
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int SCAN_TICKS   = 100000,
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       key_held,
   output logic       overrun
);

   localparam int DWELL_W = $clog2(SCAN_TICKS);
   // The debounce counter must be able to hold DEBOUNCE_CNT itself
   localparam int DEB_W   = $clog2(DEBOUNCE_CNT + 1);

   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_TICKS - 1);
   localparam logic [DEB_W-1:0]   DEB_TARGET = DEB_W'(DEBOUNCE_CNT);
   localparam logic [DEB_W-1:0]   DEB_ONE    = DEB_W'(1);

   logic [3:0]         rows_sync;
   logic [DWELL_W-1:0] dwell_cnt;
   logic               sample_tick;

   scan_state_t        state;
   scan_state_t        state_next;
   logic [1:0]         col_idx;
   logic [1:0]         col_next;
   logic [DEB_W-1:0]   deb_cnt;
   logic [DEB_W-1:0]   deb_next;
   logic [3:0]         pattern;
   logic [3:0]         pattern_next;
   logic               accept;
   logic [3:0]         accept_code;
   logic               handshake;

   row_synchronizer #(
      .WIDTH (4)
   ) u_row_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (rows),
      .sync_out (rows_sync)
   );

   // Dwell counter: the rows are sampled only in the last cycle of each
   // dwell, giving the driven column the full dwell time to settle.
   always_ff @(posedge clk) begin
      if (rst) begin
         dwell_cnt <= '0;
      end else if (sample_tick) begin
         dwell_cnt <= '0;
      end else begin
         dwell_cnt <= dwell_cnt + DWELL_W'(1);
      end
   end

   assign sample_tick = (dwell_cnt == DWELL_LAST);

   // FSM state, column index, debounce counter and captured row pattern.
   // The column only moves when a sample is taken, i.e. on a dwell wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= SCAN;
         col_idx <= 2'd0;
         deb_cnt <= '0;
         pattern <= ROWS_IDLE;
      end else begin
         state   <= state_next;
         col_idx <= col_next;
         deb_cnt <= deb_next;
         pattern <= pattern_next;
      end
   end

   // Next-state logic. Nothing moves between samples. The same counter
   // serves press debounce (DEBOUNCE) and release debounce (RELEASE), since
   // the two phases never overlap. Patterns with several rows low are never
   // accepted: in SCAN they do not qualify, and in DEBOUNCE they differ from
   // the single-row pattern that was captured.
   always_comb begin
      state_next   = state;
      col_next     = col_idx;
      deb_next     = deb_cnt;
      pattern_next = pattern;
      accept       = 1'b0;

      if (sample_tick) begin
         case (state)
            SCAN: begin
               if (single_row_low(rows_sync)) begin
                  pattern_next = rows_sync;
                  deb_next     = DEB_ONE;
                  if (DEBOUNCE_CNT == 1) begin
                     accept     = 1'b1;
                     state_next = PRESSED;
                  end else begin
                     state_next = DEBOUNCE;
                  end
               end else begin
                  col_next = col_idx + 2'd1;
               end
            end

            DEBOUNCE: begin
               if (rows_sync == pattern) begin
                  deb_next = deb_cnt + DEB_ONE;
                  if (deb_next == DEB_TARGET) begin
                     accept     = 1'b1;
                     state_next = PRESSED;
                  end
               end else begin
                  state_next = SCAN;
                  col_next   = col_idx + 2'd1;
               end
            end

            PRESSED: begin
               if (rows_sync == ROWS_IDLE) begin
                  deb_next = DEB_ONE;
                  if (DEBOUNCE_CNT == 1) begin
                     state_next = SCAN;
                     col_next   = col_idx + 2'd1;
                  end else begin
                     state_next = RELEASE;
                  end
               end
            end

            RELEASE: begin
               if (rows_sync == ROWS_IDLE) begin
                  deb_next = deb_cnt + DEB_ONE;
                  if (deb_next == DEB_TARGET) begin
                     state_next = SCAN;
                     col_next   = col_idx + 2'd1;
                  end
               end else begin
                  state_next = PRESSED;
               end
            end

            default: begin
               state_next = SCAN;
            end
         endcase
      end
   end

   // An accept only happens on a sample that equals the captured pattern,
   // so the live synced rows identify the key row.
   assign accept_code = key_lookup(row_index(rows_sync), col_idx);
   assign handshake   = key_valid && key_ready;

   // Output holding register. A new key may replace the held one only if
   // the held one is being consumed in the same cycle; otherwise the new
   // key is dropped and overrun is pulsed.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (accept) begin
            if (!key_valid || handshake) begin
               key_code  <= accept_code;
               key_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (handshake) begin
            key_valid <= 1'b0;
         end
      end
   end

   assign key_held = (state == PRESSED);
   assign cols     = ~(4'b0001 << col_idx);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_keypad_scan_ctrl
// Drives keypad_scan_ctrl from a model of a physical keypad (a pressed key
// shorts its row to its column) and checks accepted keys through a
// scoreboard queue that a separate monitor drains on every handshake.
// ---------------------------------------------------------------------------
module tb_keypad_scan_ctrl;

   localparam int SCAN_TICKS   = 8;
   localparam int DEBOUNCE_CNT = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] rows;
   logic [3:0] cols;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ready;
   logic       key_held;
   logic       overrun;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [3:0] exp_q [$];
   logic [3:0] exp_code;
   int         overrun_seen = 0;
   int         overrun_expected = 0;

   // Keypad model controls
   logic       press_act = 1'b0;
   int         press_row = 0;
   int         press_col = 0;
   logic       force_en  = 1'b0;
   logic [3:0] force_val = 4'hF;

   // Consumer controls
   logic       ready_en     = 1'b0;
   logic       ready_rand   = 1'b0;
   logic       ready_manual = 1'b0;

   logic [3:0] key_map [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'h0, 4'hF, 4'hE, 4'hD}
   };
   logic [3:0] col_drive [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   always #5 clk = ~clk;

   keypad_scan_ctrl #(
      .SCAN_TICKS   (SCAN_TICKS),
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rows      (rows),
      .cols      (cols),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_held  (key_held),
      .overrun   (overrun)
   );

   // A pressed key pulls its row low only while its column is driven low
   function automatic logic [3:0] keypad_rows(input logic [3:0] c, input logic act,
                                              input int r, input int k);
      logic [3:0] v;
      v = 4'hF;
      if (act && c[k] == 1'b0) v[r] = 1'b0;
      return v;
   endfunction

   assign rows      = force_en ? force_val : keypad_rows(cols, press_act, press_row, press_col);
   assign key_ready = ready_en ? ready_rand : ready_manual;

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // kind 0: long press (must be accepted), 1: short glitch (must not be),
   // 2: several rows low at once (must not be)
   task automatic apply_stimulus(input int kind, input int r, input int c, input int len);
      case (kind)
         0: begin
            exp_q.push_back(key_map[r][c]);
            press_row = r;
            press_col = c;
            press_act = 1'b1;
            step(len);
            check_output("held_during_press", key_held, 1);
            press_act = 1'b0;
            step(48);
         end
         1: begin
            press_row = r;
            press_col = c;
            press_act = 1'b1;
            step(len);
            press_act = 1'b0;
            step(40);
         end
         default: begin
            force_val = 4'(len);
            force_en  = 1'b1;
            step(40);
            force_en  = 1'b0;
            step(16);
         end
      endcase
   endtask

   // Monitor: every handshake must match the oldest expected key
   always @(negedge clk) begin
      if (!rst) begin
         if (key_valid && key_ready) begin
            if (exp_q.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("[TB] FAIL unexpected_key: got %0h, expected none", key_code);
            end else begin
               exp_code = exp_q.pop_front();
               check_output("key_code", key_code, exp_code);
            end
         end
         if (overrun) overrun_seen++;
      end
   end

   // Random consumer
   initial begin
      forever begin
         @(posedge clk);
         #1;
         ready_rand = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      int waited;
      int kind;
      int glen;
      logic [3:0] multi;

      // Reset state
      rst = 1'b1;
      step(3);
      rst = 1'b0;
      check_output("rst_cols", cols, 4'b1110);
      check_output("rst_key_code", key_code, 0);
      check_output("rst_key_valid", key_valid, 0);
      check_output("rst_key_held", key_held, 0);
      check_output("rst_overrun", overrun, 0);

      // Idle scan: 8 cycles per column, wrapping back to column 0
      for (int i = 0; i <= 32; i++) begin
         if (i % 8 == 0 || i == 7)
            check_output($sformatf("idle_cols_%0d", i), cols, col_drive[(i / 8) % 4]);
         step(1);
      end
      check_output("idle_key_valid", key_valid, 0);

      // Key 6 (row1, col2) held from reset: column 2 is driven from cycle 16,
      // synced rows go low at 18, samples at 23, 31, 39 -> valid at 40
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      exp_q.push_back(4'h6);
      press_row = 1;
      press_col = 2;
      press_act = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (i == 39) begin
            check_output("press_valid_early", key_valid, 0);
            check_output("press_held_early", key_held, 0);
         end
         if (i == 40) begin
            check_output("press_valid", key_valid, 1);
            check_output("press_code", key_code, 4'h6);
            check_output("press_held", key_held, 1);
            check_output("press_cols", cols, 4'b1011);
         end
         step(1);
      end
      check_output("press_cols_frozen", cols, 4'b1011);
      ready_manual = 1'b1;
      step(1);
      ready_manual = 1'b0;
      check_output("handshake_clears_valid", key_valid, 0);
      press_act = 1'b0;
      step(48);
      check_output("release_held", key_held, 0);

      // Bounce: short press gives at most two samples
      apply_stimulus(1, 2, 1, 16);
      check_output("bounce_valid", key_valid, 0);
      check_output("bounce_held", key_held, 0);

      // Two rows low on every column
      force_val = 4'b1100;
      force_en  = 1'b1;
      step(80);
      check_output("multi_valid", key_valid, 0);
      check_output("multi_held", key_held, 0);
      force_en = 1'b0;
      step(8);

      // Overrun: key 6 left pending, then key 0 pressed
      exp_q.push_back(4'h6);
      press_row = 1;
      press_col = 2;
      press_act = 1'b1;
      step(80);
      check_output("pend_valid", key_valid, 1);
      check_output("pend_code", key_code, 4'h6);
      press_act = 1'b0;
      step(48);
      press_row = 3;
      press_col = 0;
      press_act = 1'b1;
      overrun_expected = 1;
      step(80);
      check_output("overrun_code_kept", key_code, 4'h6);
      check_output("overrun_held", key_held, 1);
      check_output("overrun_count", overrun_seen, 1);
      press_act = 1'b0;
      step(48);
      ready_manual = 1'b1;
      step(1);
      ready_manual = 1'b0;
      check_output("pend_cleared", key_valid, 0);

      // Reset while PRESSED with a key pending: key is discarded
      press_row = 0;
      press_col = 0;
      press_act = 1'b1;
      waited = 0;
      while (!key_held && waited < 200) begin
         step(1);
         waited++;
      end
      check_output("wait_pressed", key_held, 1);
      check_output("pressed_valid", key_valid, 1);
      rst = 1'b1;
      press_act = 1'b0;
      step(1);
      rst = 1'b0;
      check_output("midrst_cols", cols, 4'b1110);
      check_output("midrst_key_code", key_code, 0);
      check_output("midrst_key_valid", key_valid, 0);
      check_output("midrst_key_held", key_held, 0);
      check_output("midrst_overrun", overrun, 0);
      step(8);

      // Randomized mix with a random consumer
      ready_en = 1'b1;
      for (int n = 0; n < 12; n++) begin
         kind = $urandom_range(0, 2);
         if (kind == 1) begin
            glen = $urandom_range(1, 16);
         end else if (kind == 2) begin
            multi = 4'($urandom_range(0, 15));
            while ($countones(multi) > 2) multi = 4'($urandom_range(0, 15));
            glen = int'(multi);
         end else begin
            glen = 80;
         end
         apply_stimulus(kind, $urandom_range(0, 3), $urandom_range(0, 3), glen);
      end

      // Drain the scoreboard
      waited = 0;
      while (exp_q.size() != 0 && waited < 200) begin
         step(1);
         waited++;
      end
      check_output("drain_left", exp_q.size(), 0);
      check_output("overrun_total", overrun_seen, overrun_expected);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
